instr_loader: RTL

- Writer side of the 32-entry x 20-bit instruction memory that the fetch/decode path reads.
- Accepts a byte stream over a valid/ready handshake and packs every 3 bytes into one 20-bit instruction word.
- Writes each word sequentially into instruction memory from address 0, then signals completion.
- Sits between the external program-download interface and the instruction memory write port, ahead of fetch.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/instr_packer.sv | 67 ++++++
 rtl/instr_loader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the instruction memory and its loader.
// INSTR_LOADER_CHECKSUM_EN adds the CHECK state to the loader state type.
package cpu_pkg;

  localparam int unsigned WORD_W = 20;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  // Instruction field layout
  localparam int unsigned OpcodeLsb = 0;
  localparam int unsigned OpcodeW   = 5;
  localparam int unsigned AddrALsb  = 5;
  localparam int unsigned AddrAW    = 5;
  localparam int unsigned AddrBLsb  = 10;
  localparam int unsigned AddrBW    = 5;
  localparam int unsigned AddrWLsb  = 15;
  localparam int unsigned AddrWW    = 5;

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StLoad, StWrite, StCheck, StDone} loader_state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} loader_state_e;
`endif

  // Little-endian assembly of three stream bytes; only the low nibble of byte 2 fits.
  function automatic logic [WORD_W-1:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                                  input logic [3:0] b2_lo);
    return {b2_lo, b1, b0};
  endfunction

endpackage

// File: rtl/instr_packer.sv
// Collects three stream bytes into one instruction word and flags a non-zero
// high nibble on the third byte (that nibble is dropped).
module instr_packer
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o,
  output logic              fmt_err_o
);

  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] b0_q, b0_d;
  logic [7:0] b1_q, b1_d;
  logic       last_byte;

  assign last_byte = (byte_cnt_q == 2'd2);

  // Byte position tracking and capture of the first two bytes
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    if (clear_i) begin
      byte_cnt_d = 2'd0;
      b0_d       = 8'h00;
      b1_d       = 8'h00;
    end else if (byte_valid_i) begin
      unique case (byte_cnt_q)
        2'd0: begin
          b0_d       = byte_i;
          byte_cnt_d = 2'd1;
        end
        2'd1: begin
          b1_d       = byte_i;
          byte_cnt_d = 2'd2;
        end
        default: byte_cnt_d = 2'd0;
      endcase
    end
  end

  // Partial word state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q <= 2'd0;
      b0_q       <= 8'h00;
      b1_q       <= 8'h00;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
    end
  end

  // The word completes combinationally in the cycle byte 2 is accepted
  always_comb begin
    word_valid_o = byte_valid_i && last_byte;
    word_o       = pack_word(b0_q, b1_q, byte_i[3:0]);
    fmt_err_o    = word_valid_o && (byte_i[7:4] != 4'h0);
  end

endmodule

// File: rtl/instr_loader.sv
// Instruction memory loader: packs a byte stream into 20-bit words and writes
// them from address 0 upward. Defining INSTR_LOADER_CHECKSUM_EN adds a trailing
// XOR checksum byte that is verified in a CHECK state before completion.
module instr_loader
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W:0]   count_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              error_q, error_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic              accept;
  logic              start_acc;
  logic              last_word;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic              fmt_err;

  assign accept    = in_valid_i && in_ready_o;
  assign start_acc = (state_q == StIdle) && start_i;
  assign last_word = (({1'b0, addr_q} + (ADDR_W+1)'(1)) == count_q);

  instr_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (start_acc),
    .byte_valid_i (accept && (state_q == StLoad)),
    .byte_i       (in_data_i),
    .word_valid_o (word_valid),
    .word_o       (word),
    .fmt_err_o    (fmt_err)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StLoad;
      StLoad:  if (word_valid) state_d = StWrite;
`ifdef INSTR_LOADER_CHECKSUM_EN
      StWrite: state_d = last_word ? StCheck : StLoad;
      StCheck: if (accept) state_d = StDone;
`else
      StWrite: state_d = last_word ? StDone : StLoad;
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
`ifdef INSTR_LOADER_CHECKSUM_EN
    in_ready_o = (state_q == StLoad) || (state_q == StCheck);
`else
    in_ready_o = (state_q == StLoad);
`endif
    mem_we_o    = (state_q == StWrite);
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    busy_o      = (state_q != StIdle);
    done_o      = (state_q == StDone);
    error_o     = error_q;
  end

  // Datapath next state: latched count, write address, word buffer, sticky error
  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    error_d = error_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    if (start_acc) begin
      // A count of 0 selects a full-memory load
      count_d = (count_i == '0) ? (ADDR_W+1)'(DEPTH) : count_i;
      addr_d  = '0;
      error_d = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_d   = 8'h00;
`endif
    end
    if (word_valid) wdata_d = word;
    if (fmt_err) error_d = 1'b1;
    // Wrap to 0 after address 31 is harmless: the FSM leaves WRITE for good
    if (state_q == StWrite) addr_d = addr_q + ADDR_W'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (accept && (state_q == StLoad)) xor_d = xor_q ^ in_data_i;
    if (accept && (state_q == StCheck) && (in_data_i != xor_q)) error_d = 1'b1;
`endif
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      error_q <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q   <= 8'h00;
`endif
    end else begin
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      error_q <= error_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

endmodule
